// File: rtl/riscv_mule.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) with a ready/valid writeback port.
// Define MULE_RADIX4_EN to retire two multiplier bits per cycle instead of one.
module riscv_mule (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        opcode_valid_i,
    input  logic [1:0]  opcode_op_i,
    input  logic [31:0] opcode_ra_operand_i,
    input  logic [31:0] opcode_rb_operand_i,
    input  logic [4:0]  opcode_rd_idx_i,
    output logic        opcode_accept_o,
    input  logic        kill_i,
    output logic        writeback_valid_o,
    output logic [4:0]  writeback_rd_idx_o,
    output logic [31:0] writeback_value_o,
    input  logic        writeback_accept_i,
    output logic        busy_o,
    output logic [4:0]  busy_rd_idx_o
);

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_CALC = 2'd1;
    localparam logic [1:0] STATE_DONE = 2'd2;

`ifdef MULE_RADIX4_EN
    localparam logic [5:0] ITER = 6'd16;
    localparam int         STEP = 2;
`else
    localparam logic [5:0] ITER = 6'd32;
    localparam int         STEP = 1;
`endif

    logic [1:0]  state;
    logic [5:0]  count;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic        negate;
    logic [1:0]  op;
    logic [4:0]  rd_idx;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_value;

    logic        a_signed;
    logic        b_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] acc_next;
    logic [63:0] product;
    logic [31:0] result;

    // Signs are stripped up front so the iteration is a plain unsigned shift-add.
    always_comb begin
        a_signed = (opcode_op_i == 2'b01) || (opcode_op_i == 2'b10);
        b_signed = (opcode_op_i == 2'b01);
        a_neg    = a_signed && opcode_ra_operand_i[31];
        b_neg    = b_signed && opcode_rb_operand_i[31];
        mag_a    = a_neg ? (~opcode_ra_operand_i + 32'd1) : opcode_ra_operand_i;
        mag_b    = b_neg ? (~opcode_rb_operand_i + 32'd1) : opcode_rb_operand_i;
    end

    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : 64'd0);
`ifdef MULE_RADIX4_EN
        acc_next = acc_next + (mplier[1] ? {mcand[62:0], 1'b0} : 64'd0);
`endif
        product = negate ? (~acc + 64'd1) : acc;
        result  = (op == 2'b00) ? product[31:0] : product[63:32];
    end

    assign opcode_accept_o    = (state == STATE_IDLE) && !kill_i && !rst_i;
    assign busy_o             = (state == STATE_CALC) || (state == STATE_DONE);
    assign busy_rd_idx_o      = busy_o ? rd_idx : 5'd0;
    assign writeback_valid_o  = wb_valid;
    assign writeback_rd_idx_o = wb_rd;
    assign writeback_value_o  = wb_value;

    // The extra CALC cycle at count==0 applies the sign fix-up and registers the result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= STATE_IDLE;
            count    <= 6'd0;
            acc      <= 64'd0;
            mcand    <= 64'd0;
            mplier   <= 32'd0;
            negate   <= 1'b0;
            op       <= 2'b00;
            rd_idx   <= 5'd0;
            wb_valid <= 1'b0;
            wb_rd    <= 5'd0;
            wb_value <= 32'd0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (opcode_valid_i && opcode_accept_o) begin
                        op     <= opcode_op_i;
                        rd_idx <= opcode_rd_idx_i;
                        negate <= a_neg ^ b_neg;
                        acc    <= 64'd0;
                        mcand  <= {32'd0, mag_a};
                        mplier <= mag_b;
                        count  <= ITER;
                        state  <= STATE_CALC;
                    end
                end
                STATE_CALC: begin
                    if (kill_i) begin
                        state <= STATE_IDLE;
                    end else if (count != 6'd0) begin
                        acc    <= acc_next;
                        mcand  <= mcand << STEP;
                        mplier <= mplier >> STEP;
                        count  <= count - 6'd1;
                    end else begin
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_idx;
                        wb_value <= result;
                        state    <= STATE_DONE;
                    end
                end
                STATE_DONE: begin
                    if (kill_i || writeback_accept_i) begin
                        wb_valid <= 1'b0;
                        state    <= STATE_IDLE;
                    end
                end
                default: begin
                    wb_valid <= 1'b0;
                    state    <= STATE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mule.sv
// Directed, table-driven bench for riscv_mule; honours MULE_RADIX4_EN for expected latency.
module tb_riscv_mule;

`ifdef MULE_RADIX4_EN
    localparam int ITER = 16;
`else
    localparam int ITER = 32;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        opcode_valid_i = 1'b0;
    logic [1:0]  opcode_op_i = 2'b00;
    logic [31:0] opcode_ra_operand_i = 32'd0;
    logic [31:0] opcode_rb_operand_i = 32'd0;
    logic [4:0]  opcode_rd_idx_i = 5'd0;
    logic        opcode_accept_o;
    logic        kill_i = 1'b0;
    logic        writeback_valid_o;
    logic [4:0]  writeback_rd_idx_o;
    logic [31:0] writeback_value_o;
    logic        writeback_accept_i = 1'b1;
    logic        busy_o;
    logic [4:0]  busy_rd_idx_o;

    int compared = 0;
    int mismatched = 0;

    riscv_mule dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .opcode_valid_i      (opcode_valid_i),
        .opcode_op_i         (opcode_op_i),
        .opcode_ra_operand_i (opcode_ra_operand_i),
        .opcode_rb_operand_i (opcode_rb_operand_i),
        .opcode_rd_idx_i     (opcode_rd_idx_i),
        .opcode_accept_o     (opcode_accept_o),
        .kill_i              (kill_i),
        .writeback_valid_o   (writeback_valid_o),
        .writeback_rd_idx_o  (writeback_rd_idx_o),
        .writeback_value_o   (writeback_value_o),
        .writeback_accept_i  (writeback_accept_i),
        .busy_o              (busy_o),
        .busy_rd_idx_o       (busy_rd_idx_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rd;
        logic [31:0] expected;
    } vec_t;

    vec_t vecs[11];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Presents a request at the falling edge and returns #1 after the accepting edge.
    task automatic issue_op(input logic [1:0] op, input logic [31:0] ra, input logic [31:0] rb, input logic [4:0] rd);
        @(negedge clk_i);
        opcode_valid_i      = 1'b1;
        opcode_op_i         = op;
        opcode_ra_operand_i = ra;
        opcode_rb_operand_i = rb;
        opcode_rd_idx_i     = rd;
        #1;
        check_output("accept_in_idle", {31'd0, opcode_accept_o}, 32'd1);
        @(posedge clk_i);
        #1;
        opcode_valid_i = 1'b0;
        check_output("busy_after_accept", {31'd0, busy_o}, 32'd1);
        check_output("busy_rd_idx", {27'd0, busy_rd_idx_o}, {27'd0, rd});
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (lat < 200) begin
            @(posedge clk_i);
            lat++;
            #1;
            if (writeback_valid_o) break;
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input string tag);
        int lat;
        issue_op(v.op, v.ra, v.rb, v.rd);
        wait_result(lat);
        check_output({tag, "_latency"}, lat, ITER + 1);
        check_output({tag, "_value"}, writeback_value_o, v.expected);
        check_output({tag, "_rd"}, {27'd0, writeback_rd_idx_o}, {27'd0, v.rd});
        @(posedge clk_i);
        #1;
        check_output({tag, "_valid_drop"}, {31'd0, writeback_valid_o}, 32'd0);
        check_output({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
    endtask

    task automatic watch_no_writeback(input string tag);
        logic seen;
        seen = 1'b0;
        repeat (ITER + 5) begin
            @(posedge clk_i);
            #1;
            if (writeback_valid_o) seen = 1'b1;
        end
        check_output(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        int lat;
        logic accept_seen;
        logic [31:0] held_value;

        vecs[0]  = '{2'b00, 32'd7,         32'd9,         5'd13, 32'd63};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF,  32'h00000002,  5'd1,  32'hFFFFFFFF};
        vecs[2]  = '{2'b10, 32'hFFFFFFFF,  32'h00000002,  5'd2,  32'hFFFFFFFF};
        vecs[3]  = '{2'b11, 32'hFFFFFFFF,  32'h00000002,  5'd3,  32'h00000001};
        vecs[4]  = '{2'b00, 32'hFFFFFFFF,  32'h00000002,  5'd4,  32'hFFFFFFFE};
        vecs[5]  = '{2'b01, 32'h80000000,  32'h80000000,  5'd5,  32'h40000000};
        vecs[6]  = '{2'b11, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd6,  32'hFFFFFFFE};
        vecs[7]  = '{2'b00, 32'h12345678,  32'h00000010,  5'd0,  32'h23456780};
        vecs[8]  = '{2'b10, 32'h80000000,  32'hFFFFFFFF,  5'd31, 32'h80000000};
        vecs[9]  = '{2'b01, 32'h7FFFFFFF,  32'h7FFFFFFF,  5'd9,  32'h3FFFFFFF};
        vecs[10] = '{2'b11, 32'h00010000,  32'h00010000,  5'd10, 32'h00000001};

        repeat (2) @(posedge clk_i);
        #1;
        check_output("rst_accept", {31'd0, opcode_accept_o}, 32'd0);
        check_output("rst_valid", {31'd0, writeback_valid_o}, 32'd0);
        check_output("rst_busy", {31'd0, busy_o}, 32'd0);
        check_output("rst_busy_rd", {27'd0, busy_rd_idx_o}, 32'd0);
        check_output("rst_wb_rd", {27'd0, writeback_rd_idx_o}, 32'd0);
        check_output("rst_wb_value", writeback_value_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Kill and valid together in IDLE must not start an operation.
        @(negedge clk_i);
        kill_i = 1'b1;
        opcode_valid_i = 1'b1;
        #1;
        check_output("kill_idle_accept", {31'd0, opcode_accept_o}, 32'd0);
        @(posedge clk_i);
        #1;
        kill_i = 1'b0;
        opcode_valid_i = 1'b0;
        check_output("kill_idle_busy", {31'd0, busy_o}, 32'd0);

        // Backpressure: result held stable while the core stalls.
        writeback_accept_i = 1'b0;
        issue_op(2'b00, 32'd11, 32'd12, 5'd17);
        wait_result(lat);
        check_output("bp_latency", lat, ITER + 1);
        check_output("bp_value", writeback_value_o, 32'd132);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i);
            #1;
            check_output("bp_hold_valid", {31'd0, writeback_valid_o}, 32'd1);
            check_output("bp_hold_value", writeback_value_o, 32'd132);
            check_output("bp_hold_rd", {27'd0, writeback_rd_idx_o}, 32'd17);
        end
        writeback_accept_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_output("bp_release_valid", {31'd0, writeback_valid_o}, 32'd0);
        check_output("bp_release_busy", {31'd0, busy_o}, 32'd0);

        // Kill on the fourth CALC cycle, then a fresh MUL must still work.
        issue_op(2'b00, 32'd100, 32'd200, 5'd7);
        repeat (3) @(posedge clk_i);
        #1;
        kill_i = 1'b1;
        @(posedge clk_i);
        #1;
        kill_i = 1'b0;
        check_output("kill_calc_busy", {31'd0, busy_o}, 32'd0);
        watch_no_writeback("kill_calc_no_wb");
        apply_stimulus('{2'b00, 32'd3, 32'd5, 5'd8, 32'd15}, "after_kill");

        // Kill and accept together in DONE discards the result.
        writeback_accept_i = 1'b0;
        issue_op(2'b11, 32'd4, 32'd4, 5'd12);
        wait_result(lat);
        check_output("kill_done_latency", lat, ITER + 1);
        kill_i = 1'b1;
        writeback_accept_i = 1'b1;
        @(posedge clk_i);
        #1;
        kill_i = 1'b0;
        check_output("kill_done_valid", {31'd0, writeback_valid_o}, 32'd0);
        check_output("kill_done_busy", {31'd0, busy_o}, 32'd0);

        // Reset in the middle of CALC, then a MULHU corner case.
        issue_op(2'b11, 32'h00001234, 32'h00000010, 5'd20);
        repeat (5) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        check_output("mid_rst_accept", {31'd0, opcode_accept_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        check_output("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        check_output("mid_rst_valid", {31'd0, writeback_valid_o}, 32'd0);
        rst_i = 1'b0;
        watch_no_writeback("mid_rst_no_wb");
        apply_stimulus('{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21, 32'hFFFFFFFE}, "after_rst");

        // Valid held during CALC with other operands is ignored.
        issue_op(2'b00, 32'd7, 32'd9, 5'd13);
        opcode_valid_i      = 1'b1;
        opcode_op_i         = 2'b11;
        opcode_ra_operand_i = 32'hDEADBEEF;
        opcode_rb_operand_i = 32'h0BADF00D;
        opcode_rd_idx_i     = 5'd30;
        accept_seen = 1'b0;
        lat = 0;
        while (lat < 200) begin
            if (opcode_accept_o) accept_seen = 1'b1;
            @(posedge clk_i);
            lat++;
            #1;
            if (writeback_valid_o) break;
        end
        opcode_valid_i = 1'b0;
        held_value = writeback_value_o;
        check_output("held_valid_no_accept", {31'd0, accept_seen}, 32'd0);
        check_output("held_valid_latency", lat, ITER + 1);
        check_output("held_valid_value", held_value, 32'd63);
        check_output("held_valid_rd", {27'd0, writeback_rd_idx_o}, 32'd13);
        @(posedge clk_i);
        #1;
        check_output("held_valid_idle", {31'd0, busy_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
